lsu: RTL

Load/store unit for the RV32I core, directly downstream of the ALU: consumes the ALU's `ALUOut` as the effective address for loads and stores. It performs a req/ack transaction on the data-memory port with byte-lane steering on stores and extraction plus sign/zero extension on loads. It stalls the pipeline while a transaction is outstanding and delivers load data to writeback. Misaligned accesses and bus timeouts are trapped without touching memory state.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_align.sv | 52 +++++
 rtl/lsu.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and decode helpers for the RV32I load/store unit.
package lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_t;

    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    // funct3[1:0] carries the access size for both signed and unsigned loads.
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'd1:    return lo[0];
            2'd2:    return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        st_funct3,
    input  logic [1:0]        st_addr_lo,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [3:0]        st_wstrb,
    output logic [DATA_W-1:0] st_lane_data,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_addr_lo,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data
);

    logic [DATA_W-1:0]        ld_shifted;
    logic signed [7:0]        byte_s;
    logic signed [15:0]       half_s;

    always_comb begin
        st_wstrb     = 4'b1111;
        st_lane_data = st_wdata;
        case (st_funct3)
            F3_B: begin
                st_wstrb     = 4'b0001 << st_addr_lo;
                st_lane_data = {4{st_wdata[7:0]}};
            end
            F3_H: begin
                st_wstrb     = 4'b0011 << st_addr_lo;
                st_lane_data = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Move the addressed lane down to bit 0 before extending.
    assign ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};
    assign byte_s     = ld_shifted[7:0];
    assign half_s     = ld_shifted[15:0];

    always_comb begin
        ld_data = ld_rdata;
        case (ld_funct3)
            F3_B:    ld_data = DATA_W'(byte_s);
            F3_H:    ld_data = DATA_W'(half_s);
            F3_BU:   ld_data = DATA_W'(ld_shifted[7:0]);
            F3_HU:   ld_data = DATA_W'(ld_shifted[15:0]);
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding req/ack transaction with alignment trap and bus timeout.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [2:0]        ex_funct3,
    input  logic [DATA_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [4:0]        ex_rd,
    output logic              lsu_busy,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              misaligned,
    output logic              bus_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    lsu_state_t        state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic              req_nxt, we_nxt, busy_nxt;
    logic [DATA_W-1:0] addr_nxt, wdata_nxt;
    logic [3:0]        wstrb_nxt;
    logic              wb_valid_nxt, mis_nxt, berr_nxt;
    logic [4:0]        wb_rd_nxt;
    logic [DATA_W-1:0] wb_data_nxt;

    logic              ld_p0, ld_nxt;
    logic [2:0]        f3_p0, f3_nxt;
    logic [1:0]        lo_p0, lo_nxt;
    logic [4:0]        rd_p0, rd_nxt;

    logic              accept;
    logic [3:0]        st_wstrb;
    logic [DATA_W-1:0] st_lane_data, ld_data;

    lsu_align u_align (
        .st_funct3    (ex_funct3),
        .st_addr_lo   (ex_addr[1:0]),
        .st_wdata     (ex_wdata),
        .st_wstrb     (st_wstrb),
        .st_lane_data (st_lane_data),
        .ld_funct3    (f3_p0),
        .ld_addr_lo   (lo_p0),
        .ld_rdata     (mem_rdata),
        .ld_data      (ld_data)
    );

    assign accept = ex_valid && (ex_load ^ ex_store) && f3_legal(ex_load, ex_funct3);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        req_nxt      = mem_req;
        we_nxt       = mem_we;
        busy_nxt     = lsu_busy;
        addr_nxt     = mem_addr;
        wstrb_nxt    = mem_wstrb;
        wdata_nxt    = mem_wdata;
        wb_valid_nxt = 1'b0;
        wb_rd_nxt    = '0;
        wb_data_nxt  = '0;
        mis_nxt      = 1'b0;
        berr_nxt     = 1'b0;
        ld_nxt       = ld_p0;
        f3_nxt       = f3_p0;
        lo_nxt       = lo_p0;
        rd_nxt       = rd_p0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (addr_misaligned(ex_funct3, ex_addr[1:0])) begin
                        mis_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = '0;
                        req_nxt   = 1'b1;
                        busy_nxt  = 1'b1;
                        we_nxt    = ex_store;
                        addr_nxt  = {ex_addr[DATA_W-1:2], 2'b00};
                        wstrb_nxt = ex_store ? st_wstrb : 4'b0000;
                        wdata_nxt = ex_store ? st_lane_data : '0;
                        ld_nxt    = ex_load;
                        f3_nxt    = ex_funct3;
                        lo_nxt    = ex_addr[1:0];
                        rd_nxt    = ex_rd;
                    end
                end
            end
            ST_WAIT: begin
                // Ack takes priority over the timeout limit in the same cycle.
                if (mem_ack) begin
                    state_nxt    = ST_IDLE;
                    req_nxt      = 1'b0;
                    busy_nxt     = 1'b0;
                    we_nxt       = 1'b0;
                    wb_valid_nxt = ld_p0;
                    wb_rd_nxt    = ld_p0 ? rd_p0 : 5'd0;
                    wb_data_nxt  = ld_p0 ? ld_data : '0;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    state_nxt = ST_IDLE;
                    req_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                    we_nxt    = 1'b0;
                    berr_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            lsu_busy   <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            mem_req    <= req_nxt;
            mem_we     <= we_nxt;
            lsu_busy   <= busy_nxt;
            mem_addr   <= addr_nxt;
            mem_wstrb  <= wstrb_nxt;
            mem_wdata  <= wdata_nxt;
            wb_valid   <= wb_valid_nxt;
            wb_rd      <= wb_rd_nxt;
            wb_data    <= wb_data_nxt;
            misaligned <= mis_nxt;
            bus_error  <= berr_nxt;
        end
    end

    // Load bookkeeping is only read after an accept, so it needs no reset.
    always_ff @(posedge clk) begin
        ld_p0 <= ld_nxt;
        f3_p0 <= f3_nxt;
        lo_p0 <= lo_nxt;
        rd_p0 <= rd_nxt;
    end

endmodule
